// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its downstream result accumulator:
// data width, select encodings and the accumulator FSM state type.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [1:0] SEL_SHIFT  = 2'd0;
    localparam logic [1:0] SEL_SUM2B  = 2'd1;
    localparam logic [1:0] SEL_NEG    = 2'd2;
    localparam logic [1:0] SEL_ABS3AB = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed add of a B_W-bit value onto an A_W-bit accumulator,
// clamped to the A_W-bit signed range; clip flags that a clamp happened.
module sat_add_signed #(
    parameter int A_W = 16,
    parameter int B_W = 8
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           clip
);

    localparam logic signed [A_W:0] MAX_V = {2'b00, {(A_W-1){1'b1}}};
    localparam logic signed [A_W:0] MIN_V = {2'b11, {(A_W-1){1'b0}}};

    logic signed [A_W:0] wide;

    // One guard bit is enough: |b| never exceeds the accumulator range.
    always_comb begin
        wide = $signed({a[A_W-1], a}) + $signed({{(A_W+1-B_W){b[B_W-1]}}, b});
        sum  = wide[A_W-1:0];
        clip = 1'b0;
        if (wide > MAX_V) begin
            sum  = MAX_V[A_W-1:0];
            clip = 1'b1;
        end else if (wide < MIN_V) begin
            sum  = MIN_V[A_W-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_accumulator.sv
// Collects BURST_LEN ALU results per burst into a registered summary (sum, min, max, sat).
// Define ALU_ACC_OP_HIST_EN to add the per-select histogram output out_op_hist.
module alu_result_accumulator
    import alu_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int ACC_W     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [1:0]        in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic              out_sat,
`ifdef ALU_ACC_OP_HIST_EN
    output logic [4*$clog2(BURST_LEN+1)-1:0] out_op_hist,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a rising edge where valid && ready are both
    // high; valid holds data stable until then, ready never depends on valid.
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN);

    acc_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d, beat_cnt;
    logic [ACC_W-1:0]  sum_q, sum_d, beat_sum, add_sum;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d, beat_min, beat_max;
    logic              sat_q, sat_d, beat_sat, add_clip;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
    logic              out_sat_q, out_sat_d;
    logic              in_fire, out_fire;
    logic signed [DATA_W-1:0] in_s;

    assign in_s     = in_result;
    assign in_fire  = in_valid && in_ready_q && !clear;
    assign out_fire = out_valid_q && out_ready;

    sat_add_signed #(.A_W(ACC_W), .B_W(DATA_W)) u_sat_add (
        .a    (sum_q),
        .b    (in_result),
        .sum  (add_sum),
        .clip (add_clip)
    );

    always_comb begin
        beat_sum = add_sum;
        beat_min = min_q;
        beat_max = max_q;
        beat_sat = sat_q | add_clip;
        beat_cnt = count_q + 1'b1;
        if (state_q == IDLE) begin
            beat_sum = ACC_W'(in_s);
            beat_min = in_result;
            beat_max = in_result;
            beat_sat = 1'b0;
            beat_cnt = CNT_W'(1);
        end else begin
            if ($signed(in_result) < $signed(min_q)) beat_min = in_result;
            if ($signed(in_result) > $signed(max_q)) beat_max = in_result;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        sat_d     = sat_q;
        out_sum_d = out_sum_q;
        out_min_d = out_min_q;
        out_max_d = out_max_q;
        out_sat_d = out_sat_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (in_fire) begin
                        sum_d   = beat_sum;
                        min_d   = beat_min;
                        max_d   = beat_max;
                        sat_d   = beat_sat;
                        count_d = beat_cnt;
                        state_d = ACCUM;
                        if (beat_cnt == LAST) begin
                            state_d   = HOLD;
                            out_sum_d = beat_sum;
                            out_min_d = beat_min;
                            out_max_d = beat_max;
                            out_sat_d = beat_sat;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_sat_q   <= out_sat_d;
        end
    end

`ifdef ALU_ACC_OP_HIST_EN
    logic [4*CNT_W-1:0] hist_q, hist_d;

    // Field in_sel counts beats of that select; restarts on a burst's first beat.
    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (in_fire) begin
            if (state_q == IDLE) hist_d = '0;
            hist_d[in_sel*CNT_W +: CNT_W] = hist_d[in_sel*CNT_W +: CNT_W] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    assign out_op_hist = hist_q;
`else
    logic unused_sel;
    assign unused_sel = ^in_sel;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_sat   = out_sat_q;
    assign dbg_state = state_q;

endmodule

// File: doc/alu_result_accumulator.md
Name: alu_result_accumulator

Overview:
- Sequential stage directly downstream of the team's 8-bit signed 4-op ALU (ops 0..3: shift-add, A+2B, -B, |3A-B|).
- Consumes one ALU result plus its 2-bit select per valid/ready transfer.
- Collects bursts of BURST_LEN results and produces one registered summary per burst: saturating signed sum, min, max and a sticky saturation flag.
- Its summary output feeds the next stage through a valid/ready handshake.

Parameters:
- DATA_W, 8: width of the signed ALU result.
- ACC_W, 16: width of the signed sum accumulator; must be >= DATA_W.
- BURST_LEN, 4: results per burst; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of the current burst and any pending summary.
- in_valid  input  1  in_result/in_sel are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_result  input  DATA_W  signed ALU result.
- in_sel  input  2  ALU select that produced in_result.
- out_valid  output  1  summary is valid and held stable.
- out_ready  input  1  downstream accepts the summary.
- out_sum  output  ACC_W  signed saturating sum of the burst.
- out_min  output  DATA_W  signed minimum of the burst.
- out_max  output  DATA_W  signed maximum of the burst.
- out_sat  output  1  sum clipped at least once during the burst.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the flop): state IDLE, in_ready=0 during reset, out_valid=0, out_sum=0, out_min=0, out_max=0, out_sat=0, count=0.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. On transfer: sum=sign-extended in_result, min=max=in_result, sat=0, count=1. Next state is HOLD if BURST_LEN==1, otherwise ACCUM.
  - ACCUM: in_ready=1. On transfer:
    - sum = sat_add(sum, in_result); min/max update by signed compare; sat |= clip occurred; count++.
    - When count reaches BURST_LEN, go to HOLD.
  - HOLD: in_ready=0, out_valid=1; outputs stable until the output transfer.
    - On output transfer: go to IDLE, out_valid=0 the next cycle.
    - No same-cycle input acceptance in HOLD; one bubble per burst is required.
- Latency: out_valid rises the cycle after the last input transfer of a burst.
- Saturation:
  - Compute the sum at ACC_W+1 bits.
  - If above 2^(ACC_W-1)-1, clamp to that value; if below -2^(ACC_W-1), clamp to that value. Set sat on either clamp.
  - After clamping, accumulation continues from the clamped value.
- Summary registers hold their last values while not in HOLD; only out_valid qualifies them.
- clear has priority over every transfer in the same cycle:
  - Next state IDLE, count=0, out_valid=0, sat=0.
  - A pending summary is discarded; the input beat offered in that cycle is not accepted.
- in_valid in HOLD is ignored (no transfer); the upstream must hold its data.
- Counter width: $clog2(BURST_LEN+1) bits; no wrap is possible because the burst ends at BURST_LEN.

Optional Feature:
- Macro ALU_ACC_OP_HIST_EN.
- Defined: adds output out_op_hist, 4 x $clog2(BURST_LEN+1) bits packed, field i = number of burst entries with in_sel==i.
  - The histogram is updated and cleared exactly like count and held stable in HOLD.
  - Reset and clear zero it.
- Undefined: the port and its counters do not exist.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_DATA_W=8 and the ALU select encoding constants SEL_SHIFT=0, SEL_SUM2B=1, SEL_NEG=2, SEL_ABS3AB=3.
  - The FSM state enum acc_state_t {IDLE, ACCUM, HOLD}.
- One sub-module: sat_add_signed (parameterised, combinational), returning the clamped sum and a clip flag.

Test Plan:
- Basic burst: BURST_LEN=4, results 10, -3, 127, -128 back-to-back, out_ready=1 → one cycle after the 4th beat: out_valid=1, out_sum=6, out_min=-128, out_max=127, out_sat=0; in_ready=0 for exactly one cycle.
- Backpressure: same burst, out_ready=0 for 5 cycles → outputs stable, in_ready=0 throughout; after out_ready=1 for one cycle → IDLE, in_ready=1.
- Saturation: ACC_W=8, inputs 100, 100, -50, 0 → out_sum=77 (127 clamp, then 77), out_sat=1. Also inputs -128, -128, 1, 1 → out_sum=-126, out_sat=1.
- Clear mid-burst: accept 5, 6, then clear with in_valid=1, then feed 1, 2, 3, 4 → single summary with out_sum=10, min=1, max=4; the beat under clear is not accepted.
- BURST_LEN=1 with gapped in_valid, inputs -7 then 9 → two summaries (-7,-7,-7) and (9,9,9).
- Reset mid-HOLD: assert rst_n=0 asynchronously while out_valid=1 → out_valid drops immediately and all outputs read 0. With ALU_ACC_OP_HIST_EN, sels 0, 3, 3, 1 → out_op_hist fields {1, 1, 0, 2}.
